// File: rtl/usb_reg_bus_initiator.sv
// Register-bus initiator: turns the MCU's asynchronous strobes into
// single-cycle reg_write / reg_read transactions in the usb_clk domain.
module usb_reg_bus_initiator #(
    parameter int pBYTECNT_SIZE = 7,
    parameter int pADDR_WIDTH   = 21,
    parameter int pREAD_LATENCY = 1,
    parameter int pSYNC_STAGES  = 2
) (
    input  logic                     usb_clk,
    input  logic                     reset,
    input  logic                     usb_cen,
    input  logic                     usb_rdn,
    input  logic                     usb_wrn,
    input  logic [pADDR_WIDTH-1:0]   usb_addr,
    input  logic [7:0]               usb_din,
    output logic [7:0]               usb_dout,
    output logic                     usb_isout,
    output logic [7:0]               reg_address,
    output logic [pBYTECNT_SIZE-1:0] reg_bytecnt,
    output logic [7:0]               write_data,
    input  logic [7:0]               read_data,
    output logic                     reg_read,
    output logic                     reg_write,
    output logic                     busy
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WRITE     = 3'd1,
        READ_REQ  = 3'd2,
        READ_WAIT = 3'd3,
        READ_HOLD = 3'd4,
        RELEASE   = 3'd5
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [pSYNC_STAGES-1:0] cen_sync;
    logic [pSYNC_STAGES-1:0] rdn_sync;
    logic [pSYNC_STAGES-1:0] wrn_sync;
    logic [pSYNC_STAGES-1:0] sync_ok;
    logic                    prev_rdn;
    logic                    prev_wrn;

    logic cen_s;
    logic rdn_s;
    logic wrn_s;
    logic start_wr;
    logic start_rd;
    logic capture;

    generate
        if (pADDR_WIDTH > pBYTECNT_SIZE + 8) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^usb_addr[pADDR_WIDTH-1:pBYTECNT_SIZE+8];
        end
    endgenerate

    assign cen_s = cen_sync[pSYNC_STAGES-1];
    assign rdn_s = rdn_sync[pSYNC_STAGES-1];
    assign wrn_s = wrn_sync[pSYNC_STAGES-1];

    // prev_* stay low until the reset value has been flushed out of the
    // chain, so a strobe held low across reset never looks like an edge.
    always_ff @(posedge usb_clk) begin
        if (reset) begin
            cen_sync <= '1;
            rdn_sync <= '1;
            wrn_sync <= '1;
            sync_ok  <= '0;
            prev_rdn <= 1'b0;
            prev_wrn <= 1'b0;
        end else begin
            cen_sync <= {cen_sync[pSYNC_STAGES-2:0], usb_cen};
            rdn_sync <= {rdn_sync[pSYNC_STAGES-2:0], usb_rdn};
            wrn_sync <= {wrn_sync[pSYNC_STAGES-2:0], usb_wrn};
            sync_ok  <= {sync_ok[pSYNC_STAGES-2:0], 1'b1};
            prev_rdn <= sync_ok[pSYNC_STAGES-1] & rdn_s;
            prev_wrn <= sync_ok[pSYNC_STAGES-1] & wrn_s;
        end
    end

    assign start_wr = (state == IDLE) & ~cen_s & prev_wrn & ~wrn_s;
    assign start_rd = (state == IDLE) & ~cen_s & prev_rdn & ~rdn_s
                      & ~start_wr;

    always_ff @(posedge usb_clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start_wr) begin
                    state_nxt = WRITE;
                end else if (start_rd) begin
                    state_nxt = READ_REQ;
                end
            end
            WRITE: begin
                state_nxt = RELEASE;
            end
            READ_REQ: begin
                state_nxt = (pREAD_LATENCY == 0) ? READ_HOLD : READ_WAIT;
            end
            READ_WAIT: begin
                state_nxt = READ_HOLD;
            end
            READ_HOLD: begin
                if (rdn_s | cen_s) begin
                    state_nxt = IDLE;
                end
            end
            RELEASE: begin
                if (wrn_s & rdn_s) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        reg_write = 1'b0;
        reg_read  = 1'b0;
        usb_isout = 1'b0;
        busy      = 1'b1;
        capture   = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
            end
            WRITE: begin
                reg_write = 1'b1;
            end
            READ_REQ: begin
                reg_read = 1'b1;
                capture  = (pREAD_LATENCY == 0);
            end
            READ_WAIT: begin
                capture = 1'b1;
            end
            READ_HOLD: begin
                usb_isout = 1'b1;
            end
            RELEASE: begin
                busy = 1'b1;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

    always_ff @(posedge usb_clk) begin
        if (reset) begin
            reg_address <= '0;
            reg_bytecnt <= '0;
            write_data  <= '0;
            usb_dout    <= '0;
        end else begin
            if (start_wr | start_rd) begin
                reg_address <= usb_addr[pBYTECNT_SIZE+7:pBYTECNT_SIZE];
                reg_bytecnt <= usb_addr[pBYTECNT_SIZE-1:0];
                write_data  <= usb_din;
            end
            if (capture) begin
                usb_dout <= read_data;
            end
        end
    end

endmodule
